// File: rtl/store_queue.sv
// In-order store queue: buffers executed stores, marks them committed on ROB retire,
// drains committed stores to the data cache and flags word-address conflicts for loads.
module store_queue #(
  parameter int unsigned SQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        sq_wr_valid,
  input  logic [31:0] sq_wr_addr,
  input  logic [31:0] sq_wr_data,
  input  logic [3:0]  sq_wr_strb,
  output logic        sq_allowin,
  input  logic        commit_store1_valid,
  input  logic        commit_store2_valid,
  output logic        dcache_wr_req,
  output logic [31:0] dcache_wr_addr,
  output logic [31:0] dcache_wr_data,
  output logic [3:0]  dcache_wr_strb,
  input  logic        dcache_wr_ready,
  input  logic [31:0] ld_check_addr,
  output logic        ld_conflict,
  output logic        sq_empty
);

  localparam int unsigned PW = $clog2(SQ_DEPTH);
  typedef logic [PW:0] ptr_t;

  logic [31:0] addr_q [SQ_DEPTH];
  logic [31:0] data_q [SQ_DEPTH];
  logic [3:0]  strb_q [SQ_DEPTH];

  ptr_t head, cmt, tail;
  ptr_t head_nxt, cmt_nxt, tail_nxt;
  ptr_t count, committed;
  logic do_enq, do_drain;
  logic [1:0] ncommit;
  logic [PW-1:0] idx, offs;
  logic ld_addr_unused;

  assign count      = tail - head;
  assign committed  = cmt - head;
  assign sq_allowin = count < ptr_t'(SQ_DEPTH);
  assign sq_empty   = (count == '0);

  assign dcache_wr_req = (committed != '0);
  assign do_enq        = sq_wr_valid && sq_allowin && !flush;
  assign do_drain      = dcache_wr_req && dcache_wr_ready;
  assign ncommit       = {1'b0, commit_store1_valid} + {1'b0, commit_store2_valid};

  assign head_nxt = head + ptr_t'(do_drain);
  assign cmt_nxt  = cmt + ptr_t'(ncommit);
  // Flush keeps everything up to and including this cycle's commits.
  assign tail_nxt = flush ? cmt_nxt : tail + ptr_t'(do_enq);

  // Payload is forced to zero while idle so reset leaves the bus quiet.
  assign dcache_wr_addr = dcache_wr_req ? addr_q[head[PW-1:0]] : '0;
  assign dcache_wr_data = dcache_wr_req ? data_q[head[PW-1:0]] : '0;
  assign dcache_wr_strb = dcache_wr_req ? strb_q[head[PW-1:0]] : '0;

  assign ld_addr_unused = ^ld_check_addr[1:0];

  always_comb begin
    ld_conflict = 1'b0;
    idx         = '0;
    offs        = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      idx  = PW'(i);
      // Distance from head, modulo depth, tells whether slot i is occupied.
      offs = idx - head[PW-1:0];
      if (({1'b0, offs} < count) && (addr_q[idx][31:2] == ld_check_addr[31:2])) begin
        ld_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head_nxt;
      cmt  <= cmt_nxt;
      tail <= tail_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      addr_q[tail[PW-1:0]] <= sq_wr_addr;
      data_q[tail[PW-1:0]] <= sq_wr_data;
      strb_q[tail[PW-1:0]] <= sq_wr_strb;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed stimulus for store_queue; a scoreboard holds committed stores in program
// order and a negedge monitor checks every accepted dcache write against it.
module tb_store_queue;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        sq_wr_valid;
  logic [31:0] sq_wr_addr;
  logic [31:0] sq_wr_data;
  logic [3:0]  sq_wr_strb;
  logic        sq_allowin;
  logic        commit_store1_valid;
  logic        commit_store2_valid;
  logic        dcache_wr_req;
  logic [31:0] dcache_wr_addr;
  logic [31:0] dcache_wr_data;
  logic [3:0]  dcache_wr_strb;
  logic        dcache_wr_ready;
  logic [31:0] ld_check_addr;
  logic        ld_conflict;
  logic        sq_empty;

  int compared     = 0;
  int mismatched   = 0;
  int drained      = 0;
  int illegal_seen = 0;

  st_t pend[$];
  st_t exp_q[$];

  store_queue #(.SQ_DEPTH(8)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .flush               (flush),
    .sq_wr_valid         (sq_wr_valid),
    .sq_wr_addr          (sq_wr_addr),
    .sq_wr_data          (sq_wr_data),
    .sq_wr_strb          (sq_wr_strb),
    .sq_allowin          (sq_allowin),
    .commit_store1_valid (commit_store1_valid),
    .commit_store2_valid (commit_store2_valid),
    .dcache_wr_req       (dcache_wr_req),
    .dcache_wr_addr      (dcache_wr_addr),
    .dcache_wr_data      (dcache_wr_data),
    .dcache_wr_strb      (dcache_wr_strb),
    .dcache_wr_ready     (dcache_wr_ready),
    .ld_check_addr       (ld_check_addr),
    .ld_conflict         (ld_conflict),
    .sq_empty            (sq_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic st_t mk(input logic [31:0] base, input int k);
    st_t s;
    s.addr = base + 32'(k * 4);
    s.data = base ^ (32'h9E37_0000 + 32'(k));
    s.strb = 4'(k + 1);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; the model moves commits and flushes ahead of the edge.
  task automatic drive(input logic enq, input st_t s, input logic c1, input logic c2,
                       input logic fl);
    int n;
    n = int'(c1) + int'(c2);
    assert (n <= pend.size());
    for (int k = 0; k < n; k++) exp_q.push_back(pend.pop_front());
    if (fl) pend.delete();
    if (enq && !fl && (pend.size() + exp_q.size() < 8)) pend.push_back(s);
    sq_wr_valid         = enq;
    sq_wr_addr          = s.addr;
    sq_wr_data          = s.data;
    sq_wr_strb          = s.strb;
    commit_store1_valid = c1;
    commit_store2_valid = c2;
    flush               = fl;
    step();
    sq_wr_valid         = 1'b0;
    commit_store1_valid = 1'b0;
    commit_store2_valid = 1'b0;
    flush               = 1'b0;
  endtask

  always @(negedge clk) begin
    if (resetn && dcache_wr_req && dcache_wr_ready) begin
      drained++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL drain_unexpected: got write to 0x%0h expected no write at %0t",
                 dcache_wr_addr, $time);
      end else begin
        st_t e;
        e = exp_q.pop_front();
        chk("drain_addr", dcache_wr_addr, e.addr);
        chk("drain_data", dcache_wr_data, e.data);
        chk("drain_strb", 32'(dcache_wr_strb), 32'(e.strb));
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && commit_store2_valid && !commit_store1_valid) illegal_seen++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1);
  end

  initial begin
    st_t z, one;
    int d0, next;
    logic e, c;
    z = '0;
    resetn = 1'b1; flush = 1'b0; sq_wr_valid = 1'b0;
    sq_wr_addr = '0; sq_wr_data = '0; sq_wr_strb = '0;
    commit_store1_valid = 1'b0; commit_store2_valid = 1'b0;
    dcache_wr_ready = 1'b0; ld_check_addr = '0;
    #1 resetn = 1'b0;
    #2;
    chk("rst_req", 32'(dcache_wr_req), 32'd0);
    chk("rst_allowin", 32'(sq_allowin), 32'd1);
    chk("rst_empty", 32'(sq_empty), 32'd1);
    chk("rst_conflict", 32'(ld_conflict), 32'd0);
    chk("rst_addr", dcache_wr_addr, 32'd0);
    chk("rst_data", dcache_wr_data, 32'd0);
    chk("rst_strb", 32'(dcache_wr_strb), 32'd0);
    @(negedge clk); #2 resetn = 1'b1;
    step();

    // Simultaneous flush + commit2 + enqueue + drain with 4 held, 1 committed
    for (int k = 0; k < 4; k++) drive(1'b1, mk(32'h100, k), 1'b0, 1'b0, 1'b0);
    drive(1'b0, z, 1'b1, 1'b0, 1'b0);
    chk("sim_req", 32'(dcache_wr_req), 32'd1);
    chk("sim_head_addr", dcache_wr_addr, 32'h100);
    dcache_wr_ready = 1'b1;
    drive(1'b1, mk(32'h100, 4), 1'b1, 1'b1, 1'b1);
    dcache_wr_ready = 1'b0;
    chk("sim_head", 32'(dut.head), 32'd1);
    chk("sim_cmt", 32'(dut.cmt), 32'd3);
    chk("sim_tail", 32'(dut.tail), 32'd3);
    ld_check_addr = 32'h10C; #1 chk("sim_flushed_conflict", 32'(ld_conflict), 32'd0);
    ld_check_addr = 32'h110; #1 chk("sim_dropped_conflict", 32'(ld_conflict), 32'd0);
    ld_check_addr = 32'h106; #1 chk("sim_kept_conflict", 32'(ld_conflict), 32'd1);
    dcache_wr_ready = 1'b1;
    step(); step();
    dcache_wr_ready = 1'b0;
    chk("sim_empty", 32'(sq_empty), 32'd1);

    // Flush: 5 stores, commit 2, flush; pointers start at 3
    for (int k = 0; k < 5; k++) drive(1'b1, mk(32'h300, k), 1'b0, 1'b0, 1'b0);
    drive(1'b0, z, 1'b1, 1'b1, 1'b0);
    drive(1'b0, z, 1'b0, 1'b0, 1'b1);
    chk("fl_tail", 32'(dut.tail), 32'd5);
    chk("fl_not_empty", 32'(sq_empty), 32'd0);
    dcache_wr_ready = 1'b1;
    step(); step();
    dcache_wr_ready = 1'b0;
    chk("fl_empty", 32'(sq_empty), 32'd1);
    ld_check_addr = 32'h308; #1 chk("fl_discard_conflict", 32'(ld_conflict), 32'd0);
    drive(1'b1, mk(32'h380, 0), 1'b0, 1'b0, 1'b0);
    chk("fl_slot5", dut.addr_q[5], 32'h380);
    drive(1'b0, z, 1'b1, 1'b0, 1'b0);
    dcache_wr_ready = 1'b1;
    step();
    dcache_wr_ready = 1'b0;
    chk("fl_slot5_drained", 32'(sq_empty), 32'd1);

    // Single store
    one.addr = 32'h1000; one.data = 32'hDEADBEEF; one.strb = 4'hF;
    dcache_wr_ready = 1'b1;
    drive(1'b1, one, 1'b0, 1'b0, 1'b0);
    chk("one_req_before_commit", 32'(dcache_wr_req), 32'd0);
    chk("one_not_empty", 32'(sq_empty), 32'd0);
    ld_check_addr = 32'h1000; #1 chk("one_conflict", 32'(ld_conflict), 32'd1);
    drive(1'b0, z, 1'b1, 1'b0, 1'b0);
    chk("one_req", 32'(dcache_wr_req), 32'd1);
    chk("one_addr", dcache_wr_addr, 32'h1000);
    chk("one_data", dcache_wr_data, 32'hDEADBEEF);
    step();
    chk("one_req_drop", 32'(dcache_wr_req), 32'd0);
    chk("one_empty", 32'(sq_empty), 32'd1);
    dcache_wr_ready = 1'b0;

    // Fill and backpressure
    for (int k = 0; k < 8; k++) drive(1'b1, mk(32'h5000, k), 1'b0, 1'b0, 1'b0);
    chk("full_allowin", 32'(sq_allowin), 32'd0);
    drive(1'b1, mk(32'h5000, 8), 1'b0, 1'b0, 1'b0);
    chk("full_tail", 32'(dut.tail), 32'd15);
    drive(1'b0, z, 1'b1, 1'b1, 1'b0);
    chk("full_req", 32'(dcache_wr_req), 32'd1);
    chk("full_addr", dcache_wr_addr, 32'h5000);
    for (int k = 0; k < 3; k++) drive(1'b0, z, 1'b1, 1'b1, 1'b0);
    chk("full_addr_stable", dcache_wr_addr, 32'h5000);
    d0 = drained;
    dcache_wr_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    dcache_wr_ready = 1'b0;
    chk("full_drain_count", 32'(drained - d0), 32'd8);
    chk("full_empty", 32'(sq_empty), 32'd1);

    // Wrap-around stream with ready toggling
    d0 = drained;
    next = 0;
    for (int k = 0; k < 200 && (drained - d0) < 20; k++) begin
      dcache_wr_ready = ((k % 2) == 0);
      c = (pend.size() > 0);
      e = (next < 20) && (pend.size() + exp_q.size() < 8);
      drive(e, mk(32'h8000, next), c, 1'b0, 1'b0);
      if (e) next++;
    end
    dcache_wr_ready = 1'b0;
    chk("wrap_drain_count", 32'(drained - d0), 32'd20);
    chk("wrap_empty", 32'(sq_empty), 32'd1);
    chk("wrap_head", 32'(dut.head), 32'd3);

    // Load conflicts
    drive(1'b1, mk(32'h2004, 0), 1'b0, 1'b0, 1'b0);
    ld_check_addr = 32'h2006; #1 chk("conf_same_word", 32'(ld_conflict), 32'd1);
    ld_check_addr = 32'h2008; #1 chk("conf_next_word", 32'(ld_conflict), 32'd0);
    ld_check_addr = 32'h2003; #1 chk("conf_prev_word", 32'(ld_conflict), 32'd0);

    // Commit-order violation then reset in the middle of a request
    chk("commit_order_clean", 32'(illegal_seen), 32'd0);
    drive(1'b0, z, 1'b0, 1'b1, 1'b0);
    chk("commit_order_flag", 32'(illegal_seen), 32'd1);
    chk("pre_reset_req", 32'(dcache_wr_req), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_reset_req", 32'(dcache_wr_req), 32'd0);
    chk("mid_reset_addr", dcache_wr_addr, 32'd0);
    chk("mid_reset_empty", 32'(sq_empty), 32'd1);
    pend.delete();
    exp_q.delete();
    @(negedge clk); #2 resetn = 1'b1;
    step();
    chk("post_reset_allowin", 32'(sq_allowin), 32'd1);
    chk("post_reset_req", 32'(dcache_wr_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
